// File: rtl/cordic_ci_master.sv
// Initiator for the multi-cycle custom-instruction handshake of the cosine CORDIC slave.
// Pulls operands from a valid/ready stream, screens the exponent range, issues one start
// per operand, waits for done (with timeout) and presents result plus status downstream.
module cordic_ci_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned EXP_MAX = 127
) (
    input  logic        i_clock,
    input  logic        i_aclr,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic [1:0]  o_out_status,
    output logic        o_ci_clk_en,
    output logic        o_ci_start,
    output logic [31:0] o_ci_dataa,
    input  logic [31:0] i_ci_result,
    input  logic        i_ci_done
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusRange   = 2'b01;
    localparam logic [1:0] StatusTimeout = 2'b10;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_t;

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_out_valid;
    logic [31:0]     r_out_data;
    logic [1:0]      r_out_status;
    logic            r_ci_clk_en;
    logic            r_ci_start;
    logic [31:0]     r_ci_dataa;

    logic            w_accept;
    logic            w_range_err;
    logic [CntW-1:0] w_cnt_inc;

    // in_ready depends combinationally on out_ready so HOLD can hand over with no bubble
    assign o_in_ready  = (r_state == StIdle) | ((r_state == StHold) & i_out_ready);
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_range_err = ({24'd0, i_in_data[30:23]} > EXP_MAX);
    assign w_cnt_inc   = r_cnt + 1'b1;

    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_status = r_out_status;
    assign o_ci_clk_en  = r_ci_clk_en;
    assign o_ci_start   = r_ci_start;
    assign o_ci_dataa   = r_ci_dataa;

    // Transaction FSM with registered outputs
    always_ff @(posedge i_clock or posedge i_aclr) begin
        if (i_aclr) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'd0;
            r_out_status <= StatusOk;
            r_ci_clk_en  <= 1'b0;
            r_ci_start   <= 1'b0;
            r_ci_dataa   <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle, StHold: begin
                    if (w_accept) begin
                        r_ci_dataa <= i_in_data;
                        if (w_range_err) begin
                            // Rejected operand never reaches the slave
                            r_state      <= StHold;
                            r_out_valid  <= 1'b1;
                            r_out_data   <= 32'd0;
                            r_out_status <= StatusRange;
                            r_ci_clk_en  <= 1'b0;
                            r_ci_start   <= 1'b0;
                        end else begin
                            r_state     <= StIssue;
                            r_out_valid <= 1'b0;
                            r_ci_clk_en <= 1'b1;
                            r_ci_start  <= 1'b1;
                            r_cnt       <= '0;
                        end
                    end else if ((r_state == StHold) && i_out_ready) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                    end
                end
                StIssue: begin
                    // done seen here may be left over from the previous operand: ignore it
                    r_state    <= StWait;
                    r_ci_start <= 1'b0;
                    r_cnt      <= '0;
                end
                StWait: begin
                    if (i_ci_done) begin
                        r_state      <= StHold;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= i_ci_result;
                        r_out_status <= StatusOk;
                        r_ci_clk_en  <= 1'b0;
                    end else if (w_cnt_inc == CntW'(TIMEOUT)) begin
                        r_state      <= StHold;
                        r_out_valid  <= 1'b1;
                        r_out_data   <= 32'd0;
                        r_out_status <= StatusTimeout;
                        r_ci_clk_en  <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_ci_master.sv
// Directed bench for cordic_ci_master with a behavioural CORDIC slave model.
module tb_cordic_ci_master;

    logic        clock = 1'b0;
    logic        aclr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_status;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_result;
    logic        ci_done;

    int total = 0;
    int bad   = 0;
    int n_start = 0;

    // Slave model: done 5 enabled cycles after start, result = dataa + 1, done stays high
    // (stale) until the next start. Not reset by aclr.
    logic [31:0] m_res     = 32'hDEADBEEF;
    logic        m_stale   = 1'b1;
    logic        m_busy    = 1'b0;
    int          m_cnt     = 0;
    logic        m_done_en = 1'b1;

    always @(posedge clock) begin
        if (ci_clk_en) begin
            if (ci_start) begin
                m_res   <= ci_dataa + 32'd1;
                m_busy  <= 1'b1;
                m_cnt   <= 1;
                m_stale <= 1'b0;
            end else if (m_busy && m_cnt < 5) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign ci_done   = m_done_en & (m_stale | (m_busy & (m_cnt >= 5)));
    assign ci_result = m_res;

    always @(posedge clock) begin
        if (ci_start) n_start <= n_start + 1;
    end

    cordic_ci_master #(
        .TIMEOUT(16),
        .EXP_MAX(127)
    ) u_dut (
        .i_clock     (clock),
        .i_aclr      (aclr),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_status(out_status),
        .o_ci_clk_en (ci_clk_en),
        .o_ci_start  (ci_start),
        .o_ci_dataa  (ci_dataa),
        .i_ci_result (ci_result),
        .i_ci_done   (ci_done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one operand from IDLE, then count cycles until out_valid (999 if never)
    task automatic send(input logic [31:0] d, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!out_valid) lat = 999;
    endtask

    // Drain the held result and return to IDLE
    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (out_status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", out_status); end
        total++; if ({ci_clk_en, ci_start} !== 2'b00) begin bad++; $display("FAIL reset_ci got=%b exp=00", {ci_clk_en, ci_start}); end
        total++; if (ci_dataa !== 32'd0) begin bad++; $display("FAIL reset_dataa got=%h exp=0", ci_dataa); end
    endtask

    task automatic test_basic();
        int lat;
        int n0;
        n0 = n_start;
        send(32'h3F000000, lat);
        total++; if (lat != 7) begin bad++; $display("FAIL basic_latency got=%0d exp=7", lat); end
        total++; if (out_data !== 32'h3F000001) begin bad++; $display("FAIL basic_data got=%h exp=3f000001", out_data); end
        total++; if (out_status !== 2'b00) begin bad++; $display("FAIL basic_status got=%b exp=00", out_status); end
        total++; if (n_start - n0 != 1) begin bad++; $display("FAIL basic_start_pulses got=%0d exp=1", n_start - n0); end
        total++; if (ci_dataa !== 32'h3F000000) begin bad++; $display("FAIL basic_dataa got=%h exp=3f000000", ci_dataa); end
        total++; if (ci_clk_en !== 1'b0) begin bad++; $display("FAIL basic_hold_clk_en got=%b exp=0", ci_clk_en); end
        release_out();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_range();
        int lat;
        int n0;
        n0 = n_start;
        send(32'h40490FDB, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL range_latency got=%0d exp=1", lat); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL range_data got=%h exp=0", out_data); end
        total++; if (out_status !== 2'b01) begin bad++; $display("FAIL range_status got=%b exp=01", out_status); end
        total++; if (n_start != n0) begin bad++; $display("FAIL range_no_start got=%0d exp=0", n_start - n0); end
        total++; if (ci_clk_en !== 1'b0) begin bad++; $display("FAIL range_clk_en got=%b exp=0", ci_clk_en); end
        release_out();
    endtask

    task automatic test_timeout();
        int lat;
        m_done_en = 1'b0;
        send(32'h3F800000, lat);
        total++; if (lat != 18) begin bad++; $display("FAIL timeout_latency got=%0d exp=18", lat); end
        total++; if (out_status !== 2'b10) begin bad++; $display("FAIL timeout_status got=%b exp=10", out_status); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL timeout_data got=%h exp=0", out_data); end
        release_out();
        m_done_en = 1'b1;
        send(32'h3E800000, lat);
        total++; if (lat != 7) begin bad++; $display("FAIL after_to_latency got=%0d exp=7", lat); end
        total++; if (out_data !== 32'h3E800001) begin bad++; $display("FAIL after_to_data got=%h exp=3e800001", out_data); end
        total++; if (out_status !== 2'b00) begin bad++; $display("FAIL after_to_status got=%b exp=00", out_status); end
        release_out();
    endtask

    task automatic test_hold_stall();
        int lat;
        send(32'h3F000000, lat);
        in_valid = 1'b1;
        in_data  = 32'h3F400000;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h3F000001 || out_status !== 2'b00
                || ci_clk_en !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_cycle%0d got v=%b d=%h s=%b en=%b rdy=%b exp v=1 d=3f000001 s=00 en=0 rdy=0",
                         i, out_valid, out_data, out_status, ci_clk_en, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops[8];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int last = 0;
        logic acc;
        for (int i = 0; i < 8; i++) ops[i] = 32'h3F000000 + 32'(i) * 32'h100;
        in_valid  = 1'b1;
        in_data   = ops[0];
        out_ready = 1'b1;
        while (got < 8 && cyc < 200) begin
            acc = in_valid & in_ready;
            if (in_ready && ci_clk_en) begin
                total++; bad++;
                $display("FAIL b2b_ready_busy cycle=%0d got rdy=1 exp=0", cyc);
            end
            if (out_valid) begin
                total++;
                if (out_data !== ops[got] + 32'd1 || out_status !== 2'b00) begin
                    bad++;
                    $display("FAIL b2b_result%0d got d=%h s=%b exp d=%h s=00", got, out_data, out_status,
                             ops[got] + 32'd1);
                end
                if (got > 0) begin
                    total++;
                    if (cyc - last != 7) begin
                        bad++;
                        $display("FAIL b2b_spacing%0d got=%0d exp=7", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            step();
            cyc++;
            if (acc) begin
                sent++;
                if (sent < 8) in_data = ops[sent];
                else in_valid = 1'b0;
            end
        end
        total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_aclr();
        int lat;
        in_valid = 1'b1;
        in_data  = 32'h3F000000;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        #2;
        aclr = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL aclr_handshake got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        total++; if (out_data !== 32'd0 || out_status !== 2'b00) begin bad++; $display("FAIL aclr_out got d=%h s=%b exp d=0 s=00", out_data, out_status); end
        total++; if ({ci_clk_en, ci_start} !== 2'b00 || ci_dataa !== 32'd0) begin bad++; $display("FAIL aclr_ci got en/st=%b a=%h exp 00 0", {ci_clk_en, ci_start}, ci_dataa); end
        aclr = 1'b0;
        step();
        send(32'h3E800000, lat);
        total++; if (lat != 7) begin bad++; $display("FAIL post_aclr_latency got=%0d exp=7", lat); end
        total++; if (out_data !== 32'h3E800001 || out_status !== 2'b00) begin bad++; $display("FAIL post_aclr_result got d=%h s=%b exp d=3e800001 s=00", out_data, out_status); end
        release_out();
    endtask

    initial begin
        aclr      = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #3;
        test_reset();
        #4;
        aclr = 1'b0;
        step();
        test_basic();
        test_range();
        test_timeout();
        test_hold_stall();
        test_back_to_back();
        test_aclr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
